// File: rtl/block_valid_tracker.sv
`default_nettype none
// ============================================================================
// Module      : block_valid_tracker
// Description : Per-entry valid-bit array with set/clear, one-hot decode and
//               a chunked invalidate-all (flush) sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module block_valid_tracker #(
    parameter int IDX_W     = 7,
    parameter int STRIDE    = 16,
    parameter int ZERO_NULL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [IDX_W-1:0]    set_idx,
    input  logic                clr_en,
    input  logic [IDX_W-1:0]    clr_idx,
    input  logic                flush_req,
    input  logic [IDX_W-1:0]    lookup_idx,
    output logic                lookup_valid,
    output logic [2**IDX_W-1:0] valid_vec,
    output logic [2**IDX_W-1:0] dec_onehot,
    output logic                busy,
    output logic                flush_done
);

    localparam int c_sets   = 2**IDX_W;
    localparam int c_chunks = c_sets / STRIDE;
    localparam int c_ptr_w  = (c_chunks > 1) ? $clog2(c_chunks) : 1;
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(c_chunks - 1);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_flush = 1'b1;

    // With ZERO_NULL set, index 0 is a "no entry" encoding.
    function automatic logic [c_sets-1:0] f_decode(input logic [IDX_W-1:0] idx);
        logic [c_sets-1:0] dec;
        dec = '0;
        if (ZERO_NULL != 0) begin
            if (idx != '0) dec[idx - IDX_W'(1)] = 1'b1;
        end else begin
            dec[idx] = 1'b1;
        end
        return dec;
    endfunction

    logic [0:0]         r_state;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_sets-1:0]  r_valid;
    logic [c_sets-1:0]  r_dec;
    logic               r_lookup_valid;
    logic               r_flush_done;

    logic [0:0]         w_next_state;
    logic [c_ptr_w-1:0] w_next_ptr;
    logic [c_sets-1:0]  w_next_valid;
    logic [c_sets-1:0]  w_set_dec;
    logic [c_sets-1:0]  w_clr_dec;
    logic [c_sets-1:0]  w_lookup_dec;
    logic               w_last;

    assign w_set_dec    = set_en ? f_decode(set_idx) : '0;
    assign w_clr_dec    = clr_en ? f_decode(clr_idx) : '0;
    assign w_lookup_dec = f_decode(lookup_idx);
    assign w_last       = (r_state == c_flush) && (r_ptr == c_last_ptr);

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_valid = r_valid;
        if (r_state == c_idle) begin
            if (flush_req) begin
                w_next_state = c_flush;
                w_next_ptr   = '0;
            end else begin
                // Set is OR-ed in after the clear so it wins on a collision.
                w_next_valid = (r_valid & ~w_clr_dec) | w_set_dec;
            end
        end else begin
            for (int i = 0; i < c_sets; i++) begin
                if ((i / STRIDE) == int'(r_ptr)) w_next_valid[i] = 1'b0;
            end
            if (w_last) begin
                w_next_state = c_idle;
                w_next_ptr   = '0;
            end else begin
                w_next_ptr = r_ptr + c_ptr_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_idle;
            r_ptr          <= '0;
            r_valid        <= '0;
            r_dec          <= '0;
            r_lookup_valid <= 1'b0;
            r_flush_done   <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_ptr          <= w_next_ptr;
            r_valid        <= w_next_valid;
            r_flush_done   <= w_last;
            r_dec          <= ((r_state == c_idle) && !flush_req) ? w_set_dec : '0;
            // Lookup sees this edge's updates and reads 0 for any busy cycle.
            r_lookup_valid <= (w_next_state == c_idle) && |(w_lookup_dec & w_next_valid);
        end
    end

    assign valid_vec    = r_valid;
    assign dec_onehot   = r_dec;
    assign lookup_valid = r_lookup_valid;
    assign flush_done   = r_flush_done;
    assign busy         = (r_state == c_flush);

endmodule
`default_nettype wire

// File: tb/tb_block_valid_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_valid_tracker
// Description : Self-checking bench: directed table, flush/reset corner
//               sequences, randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_valid_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic         rst = 1'b1, set_en = 1'b0, clr_en = 1'b0, flush_req = 1'b0;
    logic [6:0]   set_idx = '0, clr_idx = '0, lookup_idx = '0;
    logic         lookup_valid, busy, flush_done;
    logic [127:0] valid_vec, dec_onehot;

    block_valid_tracker dut0 (
        .clk(clk), .rst(rst), .set_en(set_en), .set_idx(set_idx),
        .clr_en(clr_en), .clr_idx(clr_idx), .flush_req(flush_req),
        .lookup_idx(lookup_idx), .lookup_valid(lookup_valid),
        .valid_vec(valid_vec), .dec_onehot(dec_onehot),
        .busy(busy), .flush_done(flush_done)
    );

    // IDX_W=4, ZERO_NULL=0, STRIDE=4
    logic        rst1 = 1'b1, se1 = 1'b0, ce1 = 1'b0, fr1 = 1'b0;
    logic [3:0]  si1 = '0, ci1 = '0, li1 = '0;
    logic        lv1, b1, fd1;
    logic [15:0] v1, d1;

    block_valid_tracker #(.IDX_W(4), .STRIDE(4), .ZERO_NULL(0)) dut1 (
        .clk(clk), .rst(rst1), .set_en(se1), .set_idx(si1),
        .clr_en(ce1), .clr_idx(ci1), .flush_req(fr1),
        .lookup_idx(li1), .lookup_valid(lv1),
        .valid_vec(v1), .dec_onehot(d1), .busy(b1), .flush_done(fd1)
    );

    // IDX_W=3, STRIDE=SETS=8, ZERO_NULL=1
    logic       rst2 = 1'b1, se2 = 1'b0, ce2 = 1'b0, fr2 = 1'b0;
    logic [2:0] si2 = '0, ci2 = '0, li2 = '0;
    logic       lv2, b2, fd2;
    logic [7:0] v2, d2;

    block_valid_tracker #(.IDX_W(3), .STRIDE(8), .ZERO_NULL(1)) dut2 (
        .clk(clk), .rst(rst2), .set_en(se2), .set_idx(si2),
        .clr_en(ce2), .clr_idx(ci2), .flush_req(fr2),
        .lookup_idx(li2), .lookup_valid(lv2),
        .valid_vec(v2), .dec_onehot(d2), .busy(b2), .flush_done(fd2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] bitv(input int n);
        logic [127:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Reference model of the default instance: 128 entries, 8 chunks of 16
    logic [127:0] m_valid = '0, m_dec = '0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_lv = 1'b0;
    int           m_chunk = 0;

    function automatic int m_bit(input int idx);
        return (idx == 0) ? -1 : idx - 1;
    endfunction

    task automatic model_step();
        int k;
        if (rst) begin
            m_valid = '0; m_dec = '0; m_busy = 1'b0; m_done = 1'b0; m_lv = 1'b0; m_chunk = 0;
        end else if (m_busy) begin
            for (int b = m_chunk * 16; b < m_chunk * 16 + 16; b++) m_valid[b] = 1'b0;
            m_chunk++;
            m_dec  = '0;
            m_done = 1'b0;
            if (m_chunk == 8) begin
                m_busy = 1'b0; m_done = 1'b1; m_chunk = 0;
            end
            k = m_bit(int'(lookup_idx));
            m_lv = !m_busy && (k >= 0) && m_valid[k];
        end else begin
            m_done = 1'b0;
            m_dec  = '0;
            if (flush_req) begin
                m_busy = 1'b1; m_chunk = 0; m_lv = 1'b0;
            end else begin
                k = m_bit(int'(clr_idx));
                if (clr_en && k >= 0) m_valid[k] = 1'b0;
                k = m_bit(int'(set_idx));
                if (set_en && k >= 0) begin
                    m_valid[k] = 1'b1; m_dec[k] = 1'b1;
                end
                k = m_bit(int'(lookup_idx));
                m_lv = (k >= 0) ? m_valid[k] : 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid_vec"}, valid_vec, m_valid);
        chk({tag, "_dec_onehot"}, dec_onehot, m_dec);
        chk({tag, "_busy"}, busy, m_busy);
        chk({tag, "_flush_done"}, flush_done, m_done);
        chk({tag, "_lookup_valid"}, lookup_valid, m_lv);
    endtask

    task automatic idle0();
        rst = 1'b0; set_en = 1'b0; clr_en = 1'b0; flush_req = 1'b0;
    endtask

    typedef struct {
        logic         rst;
        logic         set_en;
        logic [6:0]   set_idx;
        logic         clr_en;
        logic [6:0]   clr_idx;
        logic [6:0]   lookup_idx;
        logic [127:0] exp_valid;
        logic [127:0] exp_dec;
        logic         exp_lv;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic se, input int si, input logic ce,
                                input int ci, input int li, input logic [127:0] ev,
                                input logic [127:0] ed, input logic el);
        vec_t v;
        v.rst = r; v.set_en = se; v.set_idx = 7'(si); v.clr_en = ce; v.clr_idx = 7'(ci);
        v.lookup_idx = 7'(li); v.exp_valid = ev; v.exp_dec = ed; v.exp_lv = el;
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(1, 0,   0, 0,   0,   0, '0, '0, 0);
        tbl[1] = mk(0, 1,   1, 0,   0,   1, bitv(0), bitv(0), 1);
        tbl[2] = mk(0, 1, 127, 0,   0, 127, bitv(0) | bitv(126), bitv(126), 1);
        tbl[3] = mk(0, 1,   0, 0,   0,   0, bitv(0) | bitv(126), '0, 0);
        tbl[4] = mk(0, 1,   5, 1,   5,   5, bitv(0) | bitv(126) | bitv(4), bitv(4), 1);
        tbl[5] = mk(0, 0,   0, 1,   5,   5, bitv(0) | bitv(126), '0, 0);
        tbl[6] = mk(0, 1,   3, 1,   1,   2, bitv(126) | bitv(2), bitv(2), 0);
        tbl[7] = mk(0, 0,   0, 1, 127,   3, bitv(2), '0, 1);
        tbl[8] = mk(0, 1,   0, 1,   0,   0, bitv(2), '0, 0);

        #1;
        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; set_en = tbl[i].set_en; set_idx = tbl[i].set_idx;
            clr_en = tbl[i].clr_en; clr_idx = tbl[i].clr_idx;
            lookup_idx = tbl[i].lookup_idx; flush_req = 1'b0;
            tick();
            if (i == 0) begin rst1 = 1'b0; rst2 = 1'b0; end
            chk($sformatf("tbl%0d_valid_vec", i), valid_vec, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_dec_onehot", i), dec_onehot, tbl[i].exp_dec);
            chk($sformatf("tbl%0d_lookup_valid", i), lookup_valid, tbl[i].exp_lv);
            chk($sformatf("tbl%0d_busy", i), busy, 1'b0);
            chk($sformatf("tbl%0d_flush_done", i), flush_done, 1'b0);
        end

        // Fill every reachable entry, then flush while hammering set/clr/flush
        idle0();
        for (int i = 1; i < 128; i++) begin
            set_en = 1'b1; set_idx = 7'(i);
            tick();
            check_model("fill");
        end
        chk("fill_all_valid", valid_vec, {1'b0, {127{1'b1}}});
        flush_req = 1'b1; set_en = 1'b1; set_idx = 7'd10; clr_en = 1'b0;
        tick();
        check_model("flush_start");
        chk("flush_start_busy", busy, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            flush_req = 1'b1; set_en = 1'b1; set_idx = 7'($urandom_range(1, 127));
            clr_en = 1'($urandom_range(0, 1)); clr_idx = 7'($urandom_range(0, 127));
            lookup_idx = 7'($urandom_range(0, 127));
            tick();
            check_model($sformatf("flush%0d", k));
            chk($sformatf("flush%0d_low_chunks_clear", k),
                valid_vec & ((128'h1 << (16 * k)) - 128'h1), '0);
            chk($sformatf("flush%0d_busy", k), busy, (k < 8) ? 1'b1 : 1'b0);
            chk($sformatf("flush%0d_done", k), flush_done, (k == 8) ? 1'b1 : 1'b0);
        end
        chk("flush_end_valid", valid_vec, '0);
        idle0();
        tick();
        chk("flush_done_one_cycle", flush_done, 1'b0);
        check_model("post_flush");

        // Reset on the third flush cycle aborts without flush_done
        set_en = 1'b1; set_idx = 7'd20; tick();
        set_idx = 7'd100; tick();
        set_en = 1'b0; flush_req = 1'b1; tick();
        check_model("abort_c1");
        flush_req = 1'b0; tick();
        check_model("abort_c2");
        rst = 1'b1; tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", valid_vec, '0);
        chk("abort_done", flush_done, 1'b0);
        rst = 1'b0; tick();
        chk("abort_no_done", flush_done, 1'b0);
        check_model("abort_after");

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            flush_req = ($urandom_range(0, 39) == 0);
            set_en = 1'($urandom_range(0, 1));
            clr_en = 1'($urandom_range(0, 1));
            set_idx = 7'($urandom_range(0, 127));
            clr_idx = ($urandom_range(0, 3) == 0) ? set_idx : 7'($urandom_range(0, 127));
            lookup_idx = ($urandom_range(0, 1) == 0) ? set_idx : 7'($urandom_range(0, 127));
            tick();
            check_model("rand");
        end
        idle0();

        // ZERO_NULL=0, 16 entries
        se1 = 1'b1; si1 = 4'd15; tick();
        chk("zn0_set15_valid", v1, 16'h8000);
        chk("zn0_set15_dec", d1, 16'h8000);
        si1 = 4'd0; li1 = 4'd15; tick();
        chk("zn0_set0_valid", v1, 16'h8001);
        chk("zn0_set0_dec", d1, 16'h0001);
        chk("zn0_lookup15", lv1, 1'b1);
        se1 = 1'b0; li1 = 4'd14; tick();
        chk("zn0_lookup14", lv1, 1'b0);
        chk("zn0_dec_idle", d1, 16'h0000);
        fr1 = 1'b1; tick();
        fr1 = 1'b0;
        chk("zn0_flush_busy", b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("zn0_flush%0d_busy", k), b1, (k < 4) ? 1'b1 : 1'b0);
            chk($sformatf("zn0_flush%0d_done", k), fd1, (k == 4) ? 1'b1 : 1'b0);
        end
        chk("zn0_flush_valid", v1, 16'h0000);

        // STRIDE == SETS: single-cycle flush
        se2 = 1'b1; si2 = 3'd7; tick();
        chk("s8_set7_valid", v2, 8'h40);
        se2 = 1'b0; fr2 = 1'b1; tick();
        fr2 = 1'b0;
        chk("s8_busy_c1", b2, 1'b1);
        chk("s8_done_c1", fd2, 1'b0);
        chk("s8_lookup_busy", lv2, 1'b0);
        tick();
        chk("s8_busy_c2", b2, 1'b0);
        chk("s8_done_c2", fd2, 1'b1);
        chk("s8_valid_c2", v2, 8'h00);
        tick();
        chk("s8_done_c3", fd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_valid_tracker.md
BLOCK_VALID_TRACKER -- requirements
Module: block_valid_tracker

Interface
REQ-001 Parameter IDX_W, default 7: index width; SETS = 2**IDX_W entries.
REQ-002 Parameter STRIDE, default 16: entries cleared per flush cycle; power of two, 1..SETS.
REQ-003 Parameter ZERO_NULL, default 1: 1 = index 0 selects no entry and index n selects bit n-1; 0 = index n selects bit n.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 set_en  in  1  mark entry at set_idx valid.
REQ-007 set_idx  in  IDX_W  entry index for set.
REQ-008 clr_en  in  1  invalidate entry at clr_idx.
REQ-009 clr_idx  in  IDX_W  entry index for clear.
REQ-010 flush_req  in  1  start invalidate-all sequence.
REQ-011 lookup_idx  in  IDX_W  entry index to query.
REQ-012 lookup_valid  out  1  registered valid bit of lookup_idx.
REQ-013 valid_vec  out  SETS  current valid bits, bit i = entry i.
REQ-014 dec_onehot  out  SETS  registered one-hot decode of set_idx, qualified by set_en.
REQ-015 busy  out  1  high while flush in progress.
REQ-016 flush_done  out  1  one-cycle pulse at flush completion.

Function
REQ-017 Decode SHALL map index n to bit n (ZERO_NULL=0) or n-1 (ZERO_NULL=1); with ZERO_NULL=1, index 0 decodes to all-zero and bit SETS-1 is never selected.
REQ-018 FSM SHALL have states IDLE and FLUSH; IDLE -> FLUSH when flush_req=1; FLUSH -> IDLE after final chunk is cleared.
REQ-019 In IDLE, set_en=1 SHALL set the decoded bit of valid_vec on the next edge; a null decode (ZERO_NULL=1, idx 0) SHALL change nothing.
REQ-020 In IDLE, clr_en=1 SHALL clear the decoded bit of valid_vec on the next edge.
REQ-021 set_en and clr_en same cycle, same decoded bit: set SHALL win (bit ends 1); different bits: both SHALL apply.
REQ-022 flush_req with set_en/clr_en in the same IDLE cycle: flush SHALL start and set/clr SHALL be discarded.
REQ-023 In FLUSH, an internal chunk pointer starting at 0 SHALL clear valid_vec[ptr*STRIDE +: STRIDE] each cycle and increment; flush SHALL take exactly SETS/STRIDE cycles.
REQ-024 busy SHALL be 1 on every cycle the FSM is in FLUSH and 0 otherwise.
REQ-025 flush_done SHALL pulse 1 for exactly one cycle, the first cycle after FSM returns to IDLE.
REQ-026 While busy, set_en, clr_en and flush_req SHALL be ignored (no queuing); dec_onehot SHALL be 0.
REQ-027 lookup_valid SHALL equal valid_vec bit selected by lookup_idx as sampled one edge earlier (1-cycle latency), computed after that edge's updates; null decode SHALL return 0; SHALL be 0 while busy.
REQ-028 dec_onehot SHALL be decode(set_idx) registered when set_en=1 in IDLE, else 0, 1-cycle latency.
REQ-029 Pointer SHALL not wrap beyond SETS/STRIDE-1; a new flush SHALL restart at chunk 0.

Reset
REQ-030 rst=1 at an edge SHALL force: FSM IDLE, pointer 0, valid_vec 0, lookup_valid 0, dec_onehot 0, busy 0, flush_done 0.
REQ-031 rst SHALL override all other inputs the same edge, including mid-flush; an aborted flush SHALL produce no flush_done.

Verification
REQ-032 Defaults, set_en=1 set_idx=1 -> next cycle valid_vec=128'h1, dec_onehot=128'h1; set_idx=127 -> bit 126 set; set_idx=0 -> valid_vec unchanged, dec_onehot=0.
REQ-033 ZERO_NULL=0, IDX_W=4: set_idx=15 -> valid_vec=16'h8000; lookup_idx=15 next cycle -> lookup_valid=1 following edge.
REQ-034 Defaults, set and clr idx=5 same cycle with bit 4 clear -> bit 4 = 1; clr idx=5 alone -> bit 4 = 0.
REQ-035 Defaults, all bits set, flush_req pulse -> busy high 8 cycles, valid_vec clears 16 bits per cycle low-to-high, flush_done pulse on 9th cycle, valid_vec=0; set_en during busy -> no effect.
REQ-036 Defaults, rst asserted on 3rd flush cycle -> next cycle busy=0, valid_vec=0, no flush_done pulse.
REQ-037 STRIDE=SETS: flush completes in 1 cycle, busy high exactly one cycle, flush_done next cycle.
